// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: checks each received PS/2 frame, folds E0/F0 prefixes into
// key events, and queues the events in a show-ahead FIFO with valid/ready output.
`default_nettype none

module ps2_key_decoder #(
  parameter int DEPTH = 4,
  parameter int ERRW  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [10:0]     frame_i,
  input  logic            frame_stb_i,
  output logic            ev_valid_o,
  input  logic            ev_ready_i,
  output logic [7:0]      ev_code_o,
  output logic            ev_ext_o,
  output logic            ev_brk_o,
  output logic            overflow_o,
  output logic [ERRW-1:0] err_cnt_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [7:0] BYTE_EXT = 8'hE0;
  localparam logic [7:0] BYTE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXT    = 2'd1,
    S_BRK    = 2'd2,
    S_EXTBRK = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ERRW-1:0]   err_cnt_q;
  logic              overflow_q;
  logic [9:0]        mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;

  logic              w_good;
  logic [7:0]        w_byte;
  logic              w_emit;
  logic              w_emit_ext;
  logic              w_emit_brk;
  logic              w_pop;
  logic              w_full;
  logic              w_push;
  logic              w_drop;
  logic [9:0]        w_head;

  // Frame d0 (frame_i[9]) is the byte LSB.
  always_comb begin
    w_byte = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w_byte[i] = frame_i[9-i];
    end
  end

  assign w_good = (frame_i[10] == 1'b0) && (frame_i[0] == 1'b1) && (^frame_i[9:1] == 1'b1);

  always_comb begin
    state_d    = state_q;
    w_emit     = 1'b0;
    w_emit_ext = 1'b0;
    w_emit_brk = 1'b0;
    if (frame_stb_i) begin
      if (!w_good) begin
        state_d = S_IDLE;
      end else if (w_byte == BYTE_EXT) begin
        case (state_q)
          S_IDLE:  state_d = S_EXT;
          S_EXT:   state_d = S_EXT;
          default: state_d = S_EXTBRK;
        endcase
      end else if (w_byte == BYTE_BRK) begin
        case (state_q)
          S_IDLE:  state_d = S_BRK;
          S_BRK:   state_d = S_BRK;
          default: state_d = S_EXTBRK;
        endcase
      end else begin
        w_emit     = 1'b1;
        w_emit_ext = (state_q == S_EXT) || (state_q == S_EXTBRK);
        w_emit_brk = (state_q == S_BRK) || (state_q == S_EXTBRK);
        state_d    = S_IDLE;
      end
    end
  end

  assign ev_valid_o = (count_q != '0);
  assign w_full     = (count_q == CW'(DEPTH));
  assign w_pop      = ev_valid_o && ev_ready_i;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign w_push     = w_emit && (!w_full || w_pop);
  assign w_drop     = w_emit && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      err_cnt_q  <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (frame_stb_i && !w_good && (err_cnt_q != {ERRW{1'b1}})) begin
        err_cnt_q <= err_cnt_q + ERRW'(1);
      end
      if (w_drop) begin
        overflow_q <= 1'b1;
      end
      if (w_push) begin
        mem_q[wr_ptr_q] <= {w_emit_ext, w_emit_brk, w_byte};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(w_push) - CW'(w_pop);
    end
  end

  assign w_head     = mem_q[rd_ptr_q];
  assign ev_code_o  = ev_valid_o ? w_head[7:0] : 8'h00;
  assign ev_brk_o   = ev_valid_o ? w_head[8]   : 1'b0;
  assign ev_ext_o   = ev_valid_o ? w_head[9]   : 1'b0;
  assign overflow_o = overflow_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed and random frames against a queue-based event model.
`default_nettype none

module tb_ps2_key_decoder;

  localparam int DEPTH = 4;
  localparam int ERRW  = 8;
  localparam int ERRMAX = (1 << ERRW) - 1;

  logic            clk;
  logic            reset;
  logic [10:0]     frame;
  logic            frame_stb;
  logic            ev_valid;
  logic            ev_ready;
  logic [7:0]      ev_code;
  logic            ev_ext;
  logic            ev_brk;
  logic            overflow;
  logic [ERRW-1:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  ps2_key_decoder #(.DEPTH(DEPTH), .ERRW(ERRW)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_i     (frame),
    .frame_stb_i (frame_stb),
    .ev_valid_o  (ev_valid),
    .ev_ready_i  (ev_ready),
    .ev_code_o   (ev_code),
    .ev_ext_o    (ev_ext),
    .ev_brk_o    (ev_brk),
    .overflow_o  (overflow),
    .err_cnt_o   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // kind: 0 good, 1 parity error, 2 start error, 3 stop error, 4 idle all-ones
  function automatic logic [10:0] mk(input logic [7:0] b, input int kind);
    logic [10:0] f;
    f[10] = 1'b0;
    for (int i = 0; i < 8; i++) f[9-i] = b[i];
    f[1] = ~(^b);
    f[0] = 1'b1;
    case (kind)
      1: f[1]  = ~f[1];
      2: f[10] = 1'b1;
      3: f[0]  = 1'b0;
      4: f     = 11'h7FF;
      default: ;
    endcase
    return f;
  endfunction

  // Behavioural model: two prefix flags, an event queue, counters.
  logic [9:0] mq[$];
  bit         m_ext, m_brk, m_ovf;
  int         m_err;
  bit         m_good, m_has, m_pop;
  logic [7:0] m_b;
  logic [9:0] m_ev;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_ext = 0; m_brk = 0; m_ovf = 0; m_err = 0;
    end else begin
      m_pop = (mq.size() != 0) && (ev_ready == 1'b1);
      m_has = 0;
      if (frame_stb) begin
        m_good = (frame[10] == 1'b0) && (frame[0] == 1'b1) && ((^frame[9:1]) == 1'b1);
        for (int i = 0; i < 8; i++) m_b[i] = frame[9-i];
        if (!m_good) begin
          if (m_err < ERRMAX) m_err++;
          m_ext = 0; m_brk = 0;
        end else if (m_b == 8'hE0) begin
          m_ext = 1;
        end else if (m_b == 8'hF0) begin
          m_brk = 1;
        end else begin
          m_ev  = {m_ext, m_brk, m_b};
          m_has = 1;
          m_ext = 0; m_brk = 0;
        end
      end
      if (m_pop) void'(mq.pop_front());
      if (m_has) begin
        if (mq.size() < DEPTH) mq.push_back(m_ev);
        else m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("valid", {31'd0, ev_valid}, {31'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("head", {22'd0, ev_ext, ev_brk, ev_code}, {22'd0, mq[0]});
    end
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("err_cnt", {24'd0, err_cnt}, m_err);
  end

  task automatic tick(input logic stb, input logic [10:0] f, input logic rdy);
    frame_stb = stb;
    frame     = f;
    ev_ready  = rdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1'b0, 11'h7FF, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; frame = 11'h7FF; frame_stb = 1'b0; ev_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, ev_valid}, 32'd0);
    chk("rst_code", {24'd0, ev_code}, 32'd0);
    chk("rst_extbrk", {30'd0, ev_ext, ev_brk}, 32'd0);
    chk("rst_err", {24'd0, err_cnt}, 32'd0);
    reset = 1'b0;

    // 1: plain make
    tick(1'b1, mk(8'h1C, 0), 1'b1);
    chk("t1_valid", {31'd0, ev_valid}, 32'd1);
    chk("t1_ev", {22'd0, ev_ext, ev_brk, ev_code}, 32'h01C);
    tick(1'b0, 11'h7FF, 1'b1);
    chk("t1_empty", {31'd0, ev_valid}, 32'd0);

    // 2: break
    tick(1'b1, mk(8'hF0, 0), 1'b0);
    chk("t2_noev", {31'd0, ev_valid}, 32'd0);
    tick(1'b1, mk(8'h1C, 0), 1'b0);
    chk("t2_ev", {22'd0, ev_ext, ev_brk, ev_code}, 32'h11C);
    tick(1'b0, 11'h7FF, 1'b1);

    // 3: extended break
    tick(1'b1, mk(8'hE0, 0), 1'b0);
    tick(1'b1, mk(8'hF0, 0), 1'b0);
    tick(1'b1, mk(8'h75, 0), 1'b0);
    chk("t3_ev", {22'd0, ev_ext, ev_brk, ev_code}, 32'h375);
    tick(1'b0, 11'h7FF, 1'b1);
    tick(1'b1, mk(8'h2A, 0), 1'b0);
    chk("t3_idle", {22'd0, ev_ext, ev_brk, ev_code}, 32'h02A);
    tick(1'b0, 11'h7FF, 1'b1);

    // 4: errors clear the prefix
    do_reset();
    tick(1'b1, mk(8'h1C, 1), 1'b0);
    tick(1'b1, mk(8'hE0, 0), 1'b0);
    tick(1'b1, mk(8'h1C, 3), 1'b0);
    tick(1'b1, mk(8'h1C, 0), 1'b0);
    chk("t4_err", {24'd0, err_cnt}, 32'd2);
    chk("t4_ev", {22'd0, ev_ext, ev_brk, ev_code}, 32'h01C);
    tick(1'b0, 11'h7FF, 1'b1);
    chk("t4_one", {31'd0, ev_valid}, 32'd0);

    // 5: overflow and in-order drain
    for (int i = 0; i <= DEPTH; i++) tick(1'b1, mk(8'h10 + 8'(i), 0), 1'b0);
    chk("t5_ovf", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t5_order", {24'd0, ev_code}, 32'h10 + i);
      tick(1'b0, 11'h7FF, 1'b1);
    end
    chk("t5_drained", {31'd0, ev_valid}, 32'd0);

    // 6: full with simultaneous push/pop, then reset with events queued
    do_reset();
    tick(1'b1, mk(8'h33, 4), 1'b0);
    for (int i = 0; i < DEPTH; i++) tick(1'b1, mk(8'h40 + 8'(i), 0), 1'b0);
    tick(1'b1, mk(8'h4F, 0), 1'b1);
    chk("t6_noovf", {31'd0, overflow}, 32'd0);
    chk("t6_head", {24'd0, ev_code}, 32'h41);
    reset = 1'b1;
    tick(1'b0, 11'h7FF, 1'b0);
    reset = 1'b0;
    chk("t6_rst_valid", {31'd0, ev_valid}, 32'd0);
    chk("t6_rst_err", {24'd0, err_cnt}, 32'd0);

    // error counter saturation
    for (int i = 0; i < ERRMAX + 5; i++) tick(1'b1, mk(8'(i), 1 + (i % 4)), 1'b1);
    chk("sat_err", {24'd0, err_cnt}, ERRMAX);
    do_reset();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic [7:0] b;
      int kind;
      r = $urandom_range(0, 9);
      b = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom);
      kind = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
      if ($urandom_range(0, 599) == 0) reset = 1'b1;
      tick($urandom_range(0, 1) == 1, mk(b, kind),
           (i % 1000 < 500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
      reset = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
